gcd_arbiter: RTL

- Round-robin arbiter and sequencer that shares one subtraction-based GCD engine among N requesters.
- Grants one requester at a time, latches its operands, and drives the engine's start/ack handshake.
- Returns the result to the granted requester with a one-cycle done pulse.
- Handles operand values the engine cannot process (zero), and times out on an engine that stops answering.

---
 rtl/gcd_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin arbiter and sequencer sharing one subtraction-based GCD engine among N requesters.
module gcd_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 255
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [W-1:0]   result,
  output logic           busy,
  output logic           err,
  output logic           eng_start,
  output logic [W-1:0]   eng_a,
  output logic [W-1:0]   eng_b,
  input  logic [W-1:0]   eng_y,
  input  logic           eng_ack
);
  localparam int IW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT + 2);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, RELEASE, DONE, FAULT} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d, done_q, done_d;
  logic [W-1:0]  result_q, result_d, opa_q, opa_d, opb_q, opb_d, a_sel, b_sel;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, win;
  logic [TW-1:0] wd_q, wd_d, wd_inc;
  logic          err_q, err_d, eng_start_q, eng_start_d, fault;
  always_comb begin
    win = ptr_q;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr_q) + i) % N]) win = IW'((int'(ptr_q) + i) % N);
    a_sel       = a_in[int'(win) * W +: W];
    b_sel       = b_in[int'(win) * W +: W];
    wd_inc      = wd_q + 1'b1;
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    result_d    = result_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    wd_d        = wd_q;
    err_d       = err_q;
    eng_start_d = eng_start_q;
    fault       = 1'b0;
    case (state_q)
      IDLE: if (!eng_ack && |req) begin
        idx_d = win;
        gnt_d = {{(N-1){1'b0}}, 1'b1} << win;
        opa_d = a_sel;
        opb_d = b_sel;
        // gcd(x,0)=x needs no engine, which would never terminate on a zero
        if (a_sel == '0 || b_sel == '0) begin
          result_d = a_sel | b_sel;
          done_d   = {{(N-1){1'b0}}, 1'b1} << win;
          state_d  = DONE;
        end else begin
          eng_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        wd_d = wd_inc;
        if (eng_ack) begin
          result_d    = eng_y;
          eng_start_d = 1'b0;
          wd_d        = '0;
          state_d     = RELEASE;
        end else fault = (wd_inc == TW'(TIMEOUT));
      end
      RELEASE: begin
        wd_d = wd_inc;
        if (!eng_ack) begin
          done_d  = gnt_q;
          state_d = DONE;
        end else fault = (wd_inc == TW'(TIMEOUT));
      end
      DONE: begin
        gnt_d   = '0;
        ptr_d   = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
        state_d = IDLE;
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
    if (fault) begin
      state_d     = FAULT;
      gnt_d       = '0;
      eng_start_d = 1'b0;
      err_d       = 1'b1;
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      result_q    <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      ptr_q       <= '0;
      idx_q       <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      eng_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      result_q    <= result_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      eng_start_q <= eng_start_d;
    end
  end
  assign gnt       = gnt_q;
  assign done      = done_q;
  assign result    = result_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign eng_start = eng_start_q;
  assign eng_a     = opa_q;
  assign eng_b     = opb_q;
endmodule
